// File: rtl/csa4_accum_sequencer_if.sv
// Operand stream and result stream of the csa4 accumulation sequencer.
// master drives operands and accepts results; slave is the sequencer.
interface csa4_accum_sequencer_if #(
  parameter int W  = 12,
  parameter int OW = 14
);
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          in_last;
  logic          res_valid;
  logic          res_ready;
  logic [OW-1:0] res_data;
  logic [2:0]    res_count;

  modport master (
    output in_valid, in_data, in_last, res_ready,
    input  in_ready, res_valid, res_data, res_count
  );

  modport slave (
    input  in_valid, in_data, in_last, res_ready,
    output in_ready, res_valid, res_data, res_count
  );
endinterface

// File: rtl/csa4_accum_sequencer.sv
// Gathers up to four operands, drives an external 4:2 compressor,
// resolves its carry-save pair and returns the sum on a result stream.
module csa4_accum_sequencer #(
  parameter int W  = 12,
  parameter int OW = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  csa4_accum_sequencer_if.slave bus,
  output logic [W-1:0]          csa_a,
  output logic [W-1:0]          csa_b,
  output logic [W-1:0]          csa_c,
  output logic [W-1:0]          csa_d,
  input  logic [OW-1:0]         csa_out1,
  input  logic [OW-1:0]         csa_out2,
  output logic                  busy,
  output logic                  err
);

  typedef enum logic [1:0] {
    COLLECT,
    COMPRESS,
    RESOLVE,
    HOLD
  } state_t;

  state_t        state;
  state_t        nxt;
  logic [1:0]    cnt;
  logic [OW-1:0] cs1;
  logic [OW-1:0] cs2;
  logic [OW:0]   sum;
  logic          acc;
  logic          close;
  logic          hs;

  assign acc   = bus.in_valid && bus.in_ready;
  assign close = acc && (cnt == 2'd3 || bus.in_last);
  assign hs    = (state == HOLD) && bus.res_ready;
  assign sum   = {1'b0, cs1} + {1'b0, cs2};

  always_ff @(posedge clk) begin
    if (rst) state <= COLLECT;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      COLLECT:  if (close) nxt = COMPRESS;
      COMPRESS: nxt = RESOLVE;
      RESOLVE:  nxt = HOLD;
      HOLD:     if (bus.res_ready) nxt = COLLECT;
      default:  nxt = COLLECT;
    endcase
  end

  always_comb begin
    bus.in_ready = (state == COLLECT) && !rst;
    busy         = (state != COLLECT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt           <= '0;
      csa_a         <= '0;
      csa_b         <= '0;
      csa_c         <= '0;
      csa_d         <= '0;
      cs1           <= '0;
      cs2           <= '0;
      bus.res_valid <= 1'b0;
      bus.res_data  <= '0;
      bus.res_count <= '0;
      err           <= 1'b0;
    end else begin
      if (acc) begin
        unique case (cnt)
          2'd0: csa_a <= bus.in_data;
          2'd1: csa_b <= bus.in_data;
          2'd2: csa_c <= bus.in_data;
          2'd3: csa_d <= bus.in_data;
        endcase
        cnt <= cnt + 2'd1;
        if (close) bus.res_count <= {1'b0, cnt} + 3'd1;
      end
      if (state == COMPRESS) begin
        cs1 <= csa_out1;
        cs2 <= csa_out2;
      end
      if (state == RESOLVE) begin
        bus.res_data  <= sum[OW-1:0];
        bus.res_valid <= 1'b1;
        if (sum[OW]) err <= 1'b1;
      end
      // unwritten slots must read zero in the next group
      if (hs) begin
        bus.res_valid <= 1'b0;
        csa_a         <= '0;
        csa_b         <= '0;
        csa_c         <= '0;
        csa_d         <= '0;
        cnt           <= '0;
      end
    end
  end

endmodule

// File: tb/tb_csa4_accum_sequencer.sv
// Scoreboard bench for csa4_accum_sequencer with a behavioural
// compressor, random operand groups and random result back-pressure.
module tb_csa4_accum_sequencer;
  localparam int W  = 12;
  localparam int OW = 14;

  typedef struct {
    int data;
    int cnt;
    int acc;
    bit err;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  csa_a, csa_b, csa_c, csa_d;
  logic [OW-1:0] csa_out1, csa_out2;
  logic          busy, err;
  bit            fault = 1'b0;
  bit            sticky = 1'b0;
  int            rdy_mode = 0;
  int            cyc = 0;
  int            n_chk = 0;
  int            n_fail = 0;
  int            gsum = 0;
  int            gcnt = 0;
  exp_t          q[$];

  csa4_accum_sequencer_if #(.W(W), .OW(OW)) bus();

  csa4_accum_sequencer #(.W(W), .OW(OW)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .csa_a    (csa_a),
    .csa_b    (csa_b),
    .csa_c    (csa_c),
    .csa_d    (csa_d),
    .csa_out1 (csa_out1),
    .csa_out2 (csa_out2),
    .busy     (busy),
    .err      (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // any correct carry-save split works: pairwise sums
  always_comb begin
    if (fault) begin
      csa_out1 = 14'h3FFF;
      csa_out2 = 14'h3FFF;
    end else begin
      csa_out1 = 14'(csa_a) + 14'(csa_b);
      csa_out2 = 14'(csa_c) + 14'(csa_d);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic send_op(input logic [W-1:0] d, input bit l);
    int t;
    t = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = l;
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      t++;
      if (t > 200) begin
        chk("in_ready_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_data  = W'($urandom);
    gsum += int'(d);
    gcnt++;
    if (gcnt == 4 || l) begin
      exp_t e;
      e.data = gsum;
      e.cnt  = gcnt;
      e.acc  = cyc;
      if (fault) begin
        e.data = (16383 + 16383) % 16384;
        sticky = 1'b1;
      end
      e.err = sticky;
      q.push_back(e);
      gsum = 0;
      gcnt = 0;
    end
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((q.size() != 0 || bus.res_valid) && t < 400) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("idle_timeout", t < 400, 1);
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_in_ready"}, bus.in_ready, 0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_res_valid"}, bus.res_valid, 0);
    chk({nm, "_res_data"}, bus.res_data, 0);
    chk({nm, "_res_count"}, bus.res_count, 0);
    chk({nm, "_err"}, err, 0);
    chk({nm, "_csa"}, {csa_a, csa_b, csa_c, csa_d} == 0, 1);
  endtask

  // monitor: pops the scoreboard on each new result, drives res_ready
  initial begin
    bit          fresh;
    logic [13:0] held;
    fresh = 1'b1;
    held  = '0;
    bus.res_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        fresh = 1'b1;
      end else if (bus.res_valid) begin
        if (fresh) begin
          if (q.size() == 0) begin
            chk("unexpected_result", 1, 0);
          end else begin
            exp_t e;
            e = q.pop_front();
            chk("res_data", bus.res_data, e.data);
            chk("res_count", bus.res_count, e.cnt);
            chk("err", err, e.err);
            chk("latency", cyc - e.acc, 2);
          end
          held  = bus.res_data;
          fresh = 1'b0;
        end else begin
          chk("hold_stable", bus.res_data, held);
        end
      end
      case (rdy_mode)
        0:       bus.res_ready = ($urandom_range(0, 2) != 0);
        1:       bus.res_ready = 1'b0;
        default: bus.res_ready = 1'b1;
      endcase
      if (bus.res_valid && bus.res_ready && !rst) fresh = 1'b1;
    end
  end

  initial begin
    int t;
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_last  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("rst");
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("ready_after_rst", bus.in_ready, 1);

    send_op(12'd1, 1'b0);
    send_op(12'd2, 1'b0);
    send_op(12'd3, 1'b0);
    send_op(12'd4, 1'b0);
    chk("compress_busy", busy, 1);
    chk("compress_in_ready", bus.in_ready, 0);
    chk("compress_csa_d", csa_d, 4);
    wait_idle();

    repeat (4) send_op(12'hFFF, 1'b0);
    chk("max_csa", {csa_a, csa_b, csa_c, csa_d}, {4{12'hFFF}});
    wait_idle();
    chk("max_err", err, 0);

    send_op(12'd100, 1'b0);
    send_op(12'd200, 1'b0);
    send_op(12'd300, 1'b1);
    chk("partial_csa_d", csa_d, 0);
    wait_idle();

    send_op(12'h7A5, 1'b1);
    chk("single_csa_b", csa_b, 0);
    wait_idle();
    repeat (4) send_op(12'd5, 1'b0);
    wait_idle();

    rdy_mode = 1;
    send_op(12'd1, 1'b0);
    send_op(12'd2, 1'b1);
    t = 0;
    while (!bus.res_valid && t < 20) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("stall_valid_seen", bus.res_valid, 1);
    repeat (5) begin
      @(posedge clk);
      #1;
      chk("stall_in_ready", bus.in_ready, 0);
      chk("stall_busy", busy, 1);
      chk("stall_valid", bus.res_valid, 1);
    end
    rdy_mode = 2;
    t = 0;
    while (bus.res_valid && t < 10) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("post_hs_in_ready", bus.in_ready, 1);
    chk("post_hs_busy", busy, 0);
    rdy_mode = 0;
    wait_idle();

    send_op(12'd11, 1'b0);
    send_op(12'd22, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk_reset_vals("midrst");
    gsum = 0;
    gcnt = 0;
    rst  = 1'b0;
    send_op(12'd7, 1'b0);
    send_op(12'd8, 1'b0);
    send_op(12'd9, 1'b0);
    send_op(12'd10, 1'b0);
    wait_idle();

    for (int g = 0; g < 40; g++) begin
      int n;
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) begin
        logic [W-1:0] d;
        bit           l;
        if ($urandom_range(0, 3) == 0) begin
          @(posedge clk);
          #1;
        end
        d = ($urandom_range(0, 3) == 0) ? 12'hFFF : W'($urandom);
        l = (i == n - 1) && (n < 4 || $urandom_range(0, 1) == 1);
        send_op(d, l);
      end
    end
    wait_idle();

    fault = 1'b1;
    send_op(12'd1, 1'b0);
    send_op(12'd2, 1'b1);
    wait_idle();
    fault = 1'b0;
    chk("fault_err", err, 1);
    send_op(12'd5, 1'b1);
    wait_idle();
    chk("err_sticky", err, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("err_cleared", err, 0);
    rst    = 1'b0;
    sticky = 1'b0;
    gsum   = 0;
    gcnt   = 0;
    send_op(12'd9, 1'b1);
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
